// File: rtl/demux_stream_dispatcher_if.sv
// Handshake bundle between one producer, the dispatcher and N lane consumers.
//   master : producer/consumer side (drives input word, enable, mode, lane readies)
//   slave  : dispatcher side (drives ready, lane data/valid, status outputs)
interface demux_stream_dispatcher_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUTPUTS = 4,
  parameter int SEL_WIDTH   = 4
);
  logic                              Enable_In;
  logic                              Mode_In;
  logic [SEL_WIDTH-1:0]              Dest_Select_In;
  logic [DATA_WIDTH-1:0]             Data_In;
  logic                              Data_Valid_In;
  logic                              Data_Ready_Out;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] Data_Out;
  logic [NUM_OUTPUTS-1:0]            Data_Valid_Out;
  logic [NUM_OUTPUTS-1:0]            Data_Ready_In;
  logic [SEL_WIDTH-1:0]              Current_Lane_Out;
  logic                              Drop_Pulse_Out;
  logic [7:0]                        Drop_Count_Out;

  modport master (
    output Enable_In, Mode_In, Dest_Select_In, Data_In, Data_Valid_In, Data_Ready_In,
    input  Data_Ready_Out, Data_Out, Data_Valid_Out, Current_Lane_Out,
           Drop_Pulse_Out, Drop_Count_Out
  );

  modport slave (
    input  Enable_In, Mode_In, Dest_Select_In, Data_In, Data_Valid_In, Data_Ready_In,
    output Data_Ready_Out, Data_Out, Data_Valid_Out, Current_Lane_Out,
           Drop_Pulse_Out, Drop_Count_Out
  );
endinterface

// File: rtl/demux_stream_dispatcher.sv
// Registered 1:N stream demultiplexer with round-robin or directed lane choice.
// Ports:
//   Clock_In  - rising-edge clock
//   Reset_In  - asynchronous active-high reset; forces every output to 0
//   bus       - slave side of demux_stream_dispatcher_if (input word stream,
//               N output lanes, current lane, drop pulse and saturating drop count)
//
// state | meaning
// IDLE  | no word held, ready whenever enabled
// HOLD  | one word and its lane latched, presented on that lane until delivered
module demux_stream_dispatcher #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUTPUTS = 4,
  parameter int SEL_WIDTH   = 4
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  demux_stream_dispatcher_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [SEL_WIDTH-1:0]  hold_lane_q, hold_lane_d;
  logic                  hold_rr_q, hold_rr_d;
  logic [SEL_WIDTH-1:0]  rr_q, rr_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic [NUM_OUTPUTS-1:0] lane_oh;
  logic                   delivery;
  logic                   ready;
  logic                   accept;
  logic [SEL_WIDTH-1:0]   rr_adv;
  logic [SEL_WIDTH-1:0]   rr_eff;
  logic [SEL_WIDTH-1:0]   sel_lane;
  logic                   sel_bad;

  always_comb begin
    lane_oh = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      lane_oh[k] = (state_q == S_HOLD) && (hold_lane_q == SEL_WIDTH'(k));
    end
    delivery = |(lane_oh & bus.Data_Ready_In);
    // Ready is forced low during reset so every output reads 0 while it is held.
    ready    = ~Reset_In & bus.Enable_In & ((state_q == S_IDLE) | delivery);
    accept   = bus.Data_Valid_In & ready;
    rr_adv   = (rr_q == SEL_WIDTH'(NUM_OUTPUTS - 1)) ? '0 : rr_q + SEL_WIDTH'(1);
    // A word accepted on the same edge as a round-robin delivery must already
    // see the advanced pointer, otherwise back-to-back words would share a lane.
    rr_eff   = (delivery & hold_rr_q) ? rr_adv : rr_q;
    sel_lane = bus.Mode_In ? bus.Dest_Select_In : rr_eff;
    sel_bad  = bus.Mode_In &
               ({1'b0, bus.Dest_Select_In} >= (SEL_WIDTH + 1)'(NUM_OUTPUTS));
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_lane_d  = hold_lane_q;
    hold_rr_d    = hold_rr_q;
    rr_d         = rr_eff;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    if (delivery) state_d = S_IDLE;
    if (accept) begin
      if (sel_bad) begin
        // Out-of-range directed word is swallowed; it never occupies the hold reg.
        drop_pulse_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        state_d     = S_HOLD;
        hold_data_d = bus.Data_In;
        hold_lane_d = sel_lane;
        hold_rr_d   = ~bus.Mode_In;
      end
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q      <= S_IDLE;
      hold_data_q  <= '0;
      hold_lane_q  <= '0;
      hold_rr_q    <= 1'b0;
      rr_q         <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_lane_q  <= hold_lane_d;
      hold_rr_q    <= hold_rr_d;
      rr_q         <= rr_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    bus.Data_Out = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      bus.Data_Out[k*DATA_WIDTH +: DATA_WIDTH] = lane_oh[k] ? hold_data_q : '0;
    end
    bus.Data_Valid_Out   = lane_oh;
    bus.Data_Ready_Out   = ready;
    bus.Current_Lane_Out = (state_q == S_HOLD) ? hold_lane_q : rr_q;
    bus.Drop_Pulse_Out   = drop_pulse_q;
    bus.Drop_Count_Out   = drop_cnt_q;
  end

endmodule
